// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide issue controller.
//   funct3_e : RV32M operation encoding (instruction funct3 field)
//   state_e  : issue controller FSM states
//   INT_MIN / ALL_ONES : special-case result constants
//   abs32    : 32-bit two's-complement magnitude
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // |INT_MIN| wraps back to 0x80000000, which is the correct magnitude when
  // the result is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] a);
    return a[31] ? (32'd0 - a) : a;
  endfunction

endpackage

// File: rtl/muldiv_result_fix.sv
// Selects and sign-corrects the 32-bit rd value from the unit's output.
//   funct3_i : operation
//   aval_i   : product high half / remainder (bits 31:0 are all this block needs)
//   bval_i   : product low half / quotient
//   qsign_i  : negate quotient (signed DIV)
//   rsign_i  : negate remainder (signed REM)
//   result_o : rd write data
// Also used for special-case results: the caller presents the constant
// answer in the quotient/remainder slot with both sign flags clear.
module muldiv_result_fix
  import muldiv_pkg::*;
(
  input  funct3_e     funct3_i,
  input  logic [31:0] aval_i,
  input  logic [32:0] bval_i,
  input  logic        qsign_i,
  input  logic        rsign_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (funct3_i)
      MUL:                result_o = bval_i[31:0];
      // product bits 63:32 of {Aval,Bval}
      MULH, MULHSU, MULHU: result_o = {aval_i[30:0], bval_i[32]};
      DIV, DIVU:          result_o = qsign_i ? (32'd0 - bval_i[31:0]) : bval_i[31:0];
      REM, REMU:          result_o = rsign_i ? (32'd0 - aval_i) : aval_i;
      default:            result_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage initiator for the iterative 33-bit multiplier/divider unit.
//   Clk, Reset_n          : clock, async active-low reset
//   req_valid, funct3,
//   rs1, rs2, flush       : pipeline request (held until resp_valid)
//   stall, resp_valid,
//   result                : pipeline response
//   Run, div, opA, opB    : unit request
//   ready, Aval, Bval     : unit response
//
// state | meaning
// IDLE  | waiting for a request; special cases resolved here
// ISSUE | Run high, waiting for ready (cannot be aborted)
// FIX   | select and sign-correct the captured unit result
// DONE  | resp_valid pulse (suppressed if killed by flush)
module muldiv_issue_ctrl
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic        Run,
  output logic        div,
  output logic [32:0] opA,
  output logic [32:0] opB,
  input  logic        ready,
  input  logic [32:0] Aval,
  input  logic [32:0] Bval
);

  state_e      state_q, state_d;
  funct3_e     f3_q;
  logic [32:0] opa_q, opb_q;
  logic        div_q, qsign_q, rsign_q, killed_q;
  logic [31:0] aval_q;
  logic [32:0] bval_q;
  logic [31:0] result_q;

  // Remainder never exceeds 32 bits, so the top bit of Aval carries nothing.
  logic unused_aval_msb;
  assign unused_aval_msb = Aval[32];

  // Request decode
  funct3_e     f3_in;
  logic        sdiv_in, div_by_zero, overflow, special, accept;
  logic [32:0] opa_in, opb_in;

  assign f3_in       = funct3_e'(funct3);
  assign sdiv_in     = funct3[2] & ~funct3[0];   // DIV or REM
  assign div_by_zero = funct3[2] & (rs2 == 32'd0);
  assign overflow    = sdiv_in & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
  assign special     = div_by_zero | overflow;
  assign accept      = (state_q == IDLE) & req_valid & ~flush;

  always_comb begin
    opa_in = {1'b0, rs1};
    opb_in = {1'b0, rs2};
    case (f3_in)
      MUL, MULH: begin
        opa_in = {rs1[31], rs1};
        opb_in = {rs2[31], rs2};
      end
      MULHSU:    opa_in = {rs1[31], rs1};
      DIV, REM: begin
        opa_in = {1'b0, abs32(rs1)};
        opb_in = {1'b0, abs32(rs2)};
      end
      default: ;
    endcase
  end

  // Result fixer: in IDLE it produces the special-case answer from the raw
  // request, otherwise it works on the captured unit result.
  funct3_e     fix_f3;
  logic [31:0] fix_aval;
  logic [32:0] fix_bval;
  logic        fix_qsign, fix_rsign;
  logic [31:0] fix_result;

  always_comb begin
    if (state_q == IDLE) begin
      fix_f3    = f3_in;
      fix_aval  = div_by_zero ? rs1 : 32'd0;
      fix_bval  = div_by_zero ? {1'b0, ALL_ONES} : {1'b0, INT_MIN};
      fix_qsign = 1'b0;
      fix_rsign = 1'b0;
    end else begin
      fix_f3    = f3_q;
      fix_aval  = aval_q;
      fix_bval  = bval_q;
      fix_qsign = qsign_q;
      fix_rsign = rsign_q;
    end
  end

  muldiv_result_fix u_fix (
    .funct3_i (fix_f3),
    .aval_i   (fix_aval),
    .bval_i   (fix_bval),
    .qsign_i  (fix_qsign),
    .rsign_i  (fix_rsign),
    .result_o (fix_result)
  );

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : ISSUE;
      ISSUE:   if (ready)  state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Run decodes straight from state so reset drops it at once.
  always_comb begin
    Run        = (state_q == ISSUE);
    resp_valid = (state_q == DONE) & ~killed_q & ~flush;
  end

  assign stall  = req_valid & ~resp_valid & ~flush;
  assign result = result_q;
  assign div    = div_q;
  assign opA    = opa_q;
  assign opB    = opb_q;

  // Operand / result registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      f3_q     <= MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      killed_q <= 1'b0;
      aval_q   <= '0;
      bval_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        f3_q     <= f3_in;
        qsign_q  <= sdiv_in & (rs1[31] ^ rs2[31]);
        rsign_q  <= sdiv_in & rs1[31];
        killed_q <= 1'b0;
        if (special) begin
          result_q <= fix_result;
        end else begin
          opa_q <= opa_in;
          opb_q <= opb_in;
          div_q <= funct3[2];
        end
      end else if (flush && state_q != IDLE) begin
        killed_q <= 1'b1;
      end
      if (state_q == ISSUE && ready) begin
        aval_q <= Aval[31:0];
        bval_q <= Bval;
      end
      if (state_q == FIX) result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall, resp_valid, Run, div, ready;
  logic [31:0] result;
  logic [32:0] opA, opB, Aval, Bval;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  muldiv_issue_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush), .stall(stall), .resp_valid(resp_valid),
    .result(result), .Run(Run), .div(div), .opA(opA), .opB(opB),
    .ready(ready), .Aval(Aval), .Bval(Bval)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Behavioural unit: ready during the 33rd consecutive Run cycle.
  int run_cnt;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  run_cnt <= 0;
    else if (Run)  run_cnt <= run_cnt + 1;
    else           run_cnt <= 0;
  end

  logic signed [65:0] prod;
  always_comb begin
    prod  = $signed({{33{opA[32]}}, opA}) * $signed({{33{opB[32]}}, opB});
    ready = Run && (run_cnt == 32);
    if (div) begin
      Aval = (opB == 33'd0) ? 33'd0 : (opA % opB);
      Bval = (opB == 33'd0) ? 33'd0 : (opA / opB);
    end else begin
      Aval = prod[65:33];
      Bval = prod[32:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected result, watch until resp_valid.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r,
                       output int lat, output int runs,
                       output logic [32:0] oa, output logic [32:0] ob);
    int  c0;
    bit  seen_run, done;
    logic [31:0] e;
    @(negedge Clk);
    req_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    exp_q.push_back(exp_r);
    c0 = cyc; runs = 0; lat = -1; oa = '0; ob = '0; seen_run = 0; done = 0;
    #1 check({tag, "_stall_accept"}, stall, 1);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge Clk);
      if (Run) begin
        if (!seen_run) begin oa = opA; ob = opB; seen_run = 1; end
        runs++;
      end
      if (resp_valid) begin
        lat  = cyc - c0;
        done = 1;
        check({tag, "_stall_resp"}, stall, 0);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          check({tag, "_result"}, result, e);
        end
        req_valid = 1'b0;
      end
    end
    check({tag, "_resp_seen"}, done, 1);
  endtask

  int lat, runs, rsp;
  logic [32:0] oa, ob;

  initial begin
    Reset_n = 1'b0; req_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_run", Run, 0);
    check("rst_div", div, 0);
    check("rst_opA", opA, 0);
    check("rst_opB", opB, 0);
    check("rst_result", result, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_stall", stall, 0);
    Reset_n = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, lat, runs, oa, ob);
    check("mul_lat", lat, 35);
    check("mul_runs", runs, 33);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat, runs, oa, ob);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, runs, oa, ob);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, lat, runs, oa, ob);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, lat, runs, oa, ob);
    check("div_opA", oa, 33'd7);
    check("div_opB", ob, 33'd2);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, lat, runs, oa, ob);
    check("rem_lat", lat, 35);

    do_op("divu_z", 3'd5, 32'd500, 32'd0, 32'hFFFF_FFFF, lat, runs, oa, ob);
    check("divu_z_lat", lat, 1);
    check("divu_z_runs", runs, 0);
    do_op("rem_z", 3'd6, 32'd500, 32'd0, 32'h0000_01F4, lat, runs, oa, ob);
    check("rem_z_lat", lat, 1);
    check("rem_z_runs", runs, 0);
    do_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat, runs, oa, ob);
    check("div_ov_lat", lat, 1);
    check("div_ov_runs", runs, 0);
    do_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, lat, runs, oa, ob);
    check("rem_ov_runs", runs, 0);

    // Flush 5 cycles into ISSUE: unit still runs to ready, no response.
    @(negedge Clk);
    req_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    runs = 0; rsp = 0;
    for (int i = 0; i < 20 && runs < 5; i++) begin
      @(negedge Clk);
      if (Run) runs++;
    end
    flush = 1'b1;
    #1 check("flush_stall", stall, 0);
    for (int i = 0; i < 45; i++) begin
      @(negedge Clk);
      flush = 1'b0; req_valid = 1'b0;
      if (Run) runs++;
      if (resp_valid) rsp++;
    end
    check("flush_runs", runs, 33);
    check("flush_no_resp", rsp, 0);
    do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, lat, runs, oa, ob);
    check("mul_after_flush_lat", lat, 35);

    // Asynchronous reset mid-ISSUE.
    @(negedge Clk);
    req_valid = 1'b1; funct3 = 3'd3; rs1 = 32'h0000_FFFF; rs2 = 32'd3;
    runs = 0;
    for (int i = 0; i < 30 && runs < 10; i++) begin
      @(negedge Clk);
      if (Run) runs++;
    end
    check("pre_reset_run", Run, 1);
    check("pre_reset_result", result, 12);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_run", Run, 0);
    check("async_rst_resp", resp_valid, 0);
    check("async_rst_result", result, 0);
    req_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, lat, runs, oa, ob);
    check("divu_lat", lat, 35);
    do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, lat, runs, oa, ob);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Pipeline-side initiator for the iterative 33-bit `Multiplier` unit. It sits in the EX stage and accepts one RV32M instruction at a time. It conditions the operands to 33 bits, drives the unit's `Run`/`ready` handshake and stalls the pipeline until the result returns. It resolves divide-by-zero and signed-overflow cases without starting the unit, and selects and sign-corrects the 32-bit result.

## Interface
- No parameters. The datapath is fixed at XLEN=32 and the unit width at 33.
- `Clk` input 1: single clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: EX holds an M-extension instruction. Held until `resp_valid`.
- `funct3` input 3: RV32M op. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2` input 32: source operands.
- `flush` input 1: kills the instruction in flight.
- `stall` output 1: freeze the pipeline.
- `resp_valid` output 1: one-cycle pulse; `result` is valid.
- `result` output 32: rd write data.
- `Run` output 1: start/hold request to the unit.
- `div` output 1: 1 selects divide, 0 selects multiply.
- `opA`, `opB` output 33: unit operands.
- `ready` input 1: unit result valid.
- `Aval`, `Bval` input 33: unit result. Multiply: product = {Aval,Bval}. Divide: Aval = remainder, Bval = quotient.

## Operation
- States: IDLE, ISSUE, FIX, DONE.
- **IDLE**
  - `req_valid` and not `flush`: register `funct3`, `rs1`, `rs2`.
  - Special case (divide with `rs2`==0, or DIV/REM with `rs1`==0x80000000 and `rs2`==0xFFFFFFFF): load `result` directly and go to DONE.
  - Otherwise: go to ISSUE.
- **Operand rules**
  - MUL/MULH: both operands sign-extended to 33 bits.
  - MULHSU: `opA` sign-extended, `opB` zero-extended.
  - MULHU: both operands zero-extended.
  - Signed divide: operands are magnitudes, zero-extended. Record the quotient sign (`rs1[31]^rs2[31]`) and the remainder sign (`rs1[31]`).
  - Unsigned divide: operands zero-extended.
  - `div` = `funct3[2]`.
- **ISSUE**
  - `Run`=1; `opA`/`opB`/`div` stable from registers.
  - Stay until `ready`=1.
  - Then capture `Aval`/`Bval` and go to FIX.
- **FIX**
  - `Run`=0. Compute `result`:
    - MUL: `Bval[31:0]`.
    - MULH/MULHSU/MULHU: {`Aval[30:0]`, `Bval[32]`}, i.e. product bits 63:32.
    - DIV(U): `Bval[31:0]`, negated if the quotient sign is set (DIV only).
    - REM(U): `Aval[31:0]`, negated if the remainder sign is set (REM only).
  - Go to DONE.
- **DONE**
  - `resp_valid`=1 for one cycle; `Run`=0.
  - Go to IDLE.
- **Special-case results**
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `rs1`.
  - Overflow: DIV → 0x80000000; REM → 0.
- **Stall:** `stall` = `req_valid` & ~`resp_valid` & ~`flush`.
- **Flush**
  - The request is marked killed.
  - In ISSUE, `Run` stays high until `ready`, because the unit cannot be aborted.
  - FIX and DONE still run, but `resp_valid` is suppressed.
  - The next request is accepted only from IDLE.

## Timing
- **Reset values:** state IDLE; `Run`=0, `div`=0, `opA`=`opB`=0, `result`=0, `resp_valid`=0. `stall` follows its combinational equation.
- **Reset mid-operation:** return to IDLE immediately and drop `Run` asynchronously.
- **Latency, normal path:** accept cycle, N ISSUE cycles (N = cycles until `ready`), FIX, then DONE. `resp_valid` rises N+2 cycles after accept.
- **Latency, special case:** accept, then DONE. `resp_valid` rises 1 cycle after accept.
- **Gap between operations:** `Run` is low for at least 3 cycles (FIX, DONE, IDLE) before a new ISSUE. This guarantees the unit sees a deasserted `Run`.
- **Back-to-back:** the pipeline advances on the `resp_valid` cycle, so the next instruction is presented while the block is back in IDLE.
- **`ready` in IDLE, FIX or DONE:** ignored.
- **`ready` while `Run` is low:** never acted on.

## Structure
- **`muldiv_pkg`:**
  - `funct3` enum (MUL..REMU)
  - state enum (IDLE, ISSUE, FIX, DONE)
  - constants INT_MIN = 0x80000000 and ALL_ONES = 0xFFFFFFFF
- **Sub-module `muldiv_result_fix`:** combinational. Inputs `funct3`, `Aval`, `Bval`, sign flags. Output the 32-bit `result`. It is reused for the special-case mux.
- **Top level:** FSM plus operand/result registers.

## Test plan
All unit-path scenarios use a behavioural multiplier/divider model with `ready` asserted after 33 cycles.
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB. `resp_valid` 35 cycles after accept. `Run` high for exactly the ISSUE cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed division of 0xFFFFFFF9 by 2:
  - DIV → 0xFFFFFFFD and REM → 0xFFFFFFFF.
  - `opA` must be 7 and `opB` must be 2.
- Special cases, each with `resp_valid` 1 cycle after accept and `Run` never asserted:
  - DIVU 500/0 → 0xFFFFFFFF; REM 500/0 → 500 (500 = 0x1F4).
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush asserted 5 cycles into ISSUE:
  - `Run` stays high until `ready`.
  - No `resp_valid`.
  - The next MUL 3×4 → 12 completes normally.
- `Reset_n` low mid-ISSUE:
  - `Run`, `resp_valid` and `result` go to 0 without waiting for a clock edge.
  - After release, a DIVU 100/7 → 14 completes normally.
